// File: rtl/fll_norm_sched_if.sv
// Channel, encoder and result signals of the FLL normalization scheduler.
// res_zero exists only when FLL_SCHED_ZERO_DET_EN is defined.
interface fll_norm_sched_if #(
    parameter int NUM_CHAN = 4,
    parameter int CHAN_W   = 2
);
    logic                       enable;
    logic [NUM_CHAN-1:0]        req;
    logic [NUM_CHAN-1:0][17:0]  mag;
    logic [NUM_CHAN-1:0]        ack;
    logic [17:0]                enc_in;
    logic [4:0]                 enc_pos;
    logic                       res_valid;
    logic [CHAN_W-1:0]          res_chan;
    logic [4:0]                 res_pos;
    logic [3:0]                 res_shift;
`ifdef FLL_SCHED_ZERO_DET_EN
    logic                       res_zero;
`endif
    logic                       busy;

    modport master (
        output enable, req, mag, enc_pos,
        input  ack, enc_in, res_valid, res_chan, res_pos, res_shift,
`ifdef FLL_SCHED_ZERO_DET_EN
        input  res_zero,
`endif
        input  busy
    );

    modport slave (
        input  enable, req, mag, enc_pos,
        output ack, enc_in, res_valid, res_chan, res_pos, res_shift,
`ifdef FLL_SCHED_ZERO_DET_EN
        output res_zero,
`endif
        output busy
    );
endinterface

// File: rtl/fll_norm_sched.sv
// Round-robin time-multiplexer of one shared 18-bit leading-one encoder across
// NUM_CHAN FLL channels. Define FLL_SCHED_ZERO_DET_EN to add the res_zero output.

// Per-channel in-flight flag and eligibility.
module fll_sched_lane (
    input  logic clk,
    input  logic reset_n,
    input  logic req,
    input  logic enable,
    input  logic set,
    input  logic clr,
    output logic inflight,
    output logic elig
);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  inflight <= 1'b0;
        else if (clr)  inflight <= 1'b0;
        else if (set)  inflight <= 1'b1;
    end

    assign elig = req & enable & ~inflight;
endmodule

module fll_norm_sched #(
    parameter int NUM_CHAN = 4,
    parameter int CHAN_W   = 2,
    parameter int ENC_LAT  = 2,
    parameter int POS_MIN  = 7
) (
    input  logic             clk,
    input  logic             reset_n,
    fll_norm_sched_if.slave  bus
);
    logic [NUM_CHAN-1:0]            elig, inflight, gnt_oh, clr_oh;
    logic [CHAN_W-1:0]              ptr, gnt_idx, cand;
    logic                           gnt_vld;
    // Stage 0 is written at grant; stage ENC_LAT lines up with the matching enc_pos.
    logic [ENC_LAT:0]               vld_pipe;
    logic [ENC_LAT:0][CHAN_W-1:0]   chan_pipe;
    logic [4:0]                     shift_full;
`ifdef FLL_SCHED_ZERO_DET_EN
    logic [ENC_LAT:0]               zero_pipe;
    logic                           mag_zero;
`endif

    for (genvar c = 0; c < NUM_CHAN; c++) begin : g_lane
        fll_sched_lane u_lane (
            .clk      (clk),
            .reset_n  (reset_n),
            .req      (bus.req[c]),
            .enable   (bus.enable),
            .set      (gnt_oh[c]),
            .clr      (clr_oh[c]),
            .inflight (inflight[c]),
            .elig     (elig[c])
        );
    end

    // Walk from farthest to nearest so the first eligible after ptr wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int i = NUM_CHAN; i >= 1; i--) begin
            cand = CHAN_W'((int'(ptr) + i) % NUM_CHAN);
            if (elig[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    always_comb begin
        gnt_oh = '0;
        clr_oh = '0;
        if (gnt_vld)           gnt_oh[gnt_idx] = 1'b1;
        if (vld_pipe[ENC_LAT]) clr_oh[chan_pipe[ENC_LAT]] = 1'b1;
    end

    assign shift_full = bus.enc_pos - 5'(POS_MIN);
    assign bus.busy   = (|inflight) | (|elig);
`ifdef FLL_SCHED_ZERO_DET_EN
    assign mag_zero   = (bus.mag[gnt_idx] == 18'd0);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr           <= CHAN_W'(NUM_CHAN - 1);
            bus.ack       <= '0;
            bus.enc_in    <= '0;
            vld_pipe      <= '0;
            chan_pipe     <= '0;
            bus.res_valid <= 1'b0;
            bus.res_chan  <= '0;
            bus.res_pos   <= '0;
            bus.res_shift <= '0;
`ifdef FLL_SCHED_ZERO_DET_EN
            zero_pipe     <= '0;
            bus.res_zero  <= 1'b0;
`endif
        end else begin
            bus.ack   <= gnt_oh;
            vld_pipe  <= {vld_pipe[ENC_LAT-1:0], gnt_vld};
            chan_pipe <= {chan_pipe[ENC_LAT-1:0], gnt_idx};
`ifdef FLL_SCHED_ZERO_DET_EN
            zero_pipe <= {zero_pipe[ENC_LAT-1:0], gnt_vld & mag_zero};
`endif
            if (gnt_vld) begin
                bus.enc_in <= bus.mag[gnt_idx];
                ptr        <= gnt_idx;
            end
            bus.res_valid <= vld_pipe[ENC_LAT];
            if (vld_pipe[ENC_LAT]) begin
                bus.res_chan <= chan_pipe[ENC_LAT];
                bus.res_pos  <= bus.enc_pos;
`ifdef FLL_SCHED_ZERO_DET_EN
                // Encoder reports POS_MIN for zero too; the flag tells them apart.
                bus.res_zero  <= zero_pipe[ENC_LAT];
                bus.res_shift <= zero_pipe[ENC_LAT] ? 4'd0 : shift_full[3:0];
`else
                bus.res_shift <= shift_full[3:0];
`endif
            end
        end
    end
endmodule
